// File: rtl/maxnet_feeder.sv
// Host-side feeder for the Maxnet core: packs four words, pulses start, waits, returns Result.
// Optional MAXNET_CHECK_EN adds a reference-max tracker that flags mismatching results on chk_err.
module maxnet_feeder #(
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 64,
   parameter int CNT_W       = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] mx_a0,
   output logic [DATA_W-1:0] mx_a1,
   output logic [DATA_W-1:0] mx_a2,
   output logic [DATA_W-1:0] mx_a3,
   output logic              mx_start,
   input  logic [DATA_W-1:0] mx_result,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              chk_err
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [1:0]        idx_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] a_r [4];
   logic              in_ready_r;
   logic              mx_start_r;
   logic              busy_r;
   logic [DATA_W-1:0] out_data_r;
   logic              out_valid_r;
   logic              beat_s;
   logic              done_s;
   logic              take_s;

   assign beat_s = in_valid & in_ready_r;
   assign done_s = (cnt_r == CNT_W'(WAIT_CYCLES - 1));
   assign take_s = out_valid_r & out_ready;

   assign in_ready  = in_ready_r;
   assign mx_a0     = a_r[0];
   assign mx_a1     = a_r[1];
   assign mx_a2     = a_r[2];
   assign mx_a3     = a_r[3];
   assign mx_start  = mx_start_r;
   assign busy      = busy_r;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;

   // Next-state decode for the load/start/wait/out sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         LOAD: begin
            if (beat_s && (idx_r == 2'd3)) begin
               state_nxt_s = START;
            end else begin
               state_nxt_s = LOAD;
            end
         end
         START: state_nxt_s = WAIT;
         WAIT: begin
            if (done_s) begin
               state_nxt_s = OUT;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         OUT: begin
            if (take_s) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = OUT;
            end
         end
         default: state_nxt_s = LOAD;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= LOAD;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Slot index, settle counter, operand registers and handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r       <= 2'd0;
         cnt_r       <= {CNT_W{1'b0}};
         a_r[0]      <= {DATA_W{1'b0}};
         a_r[1]      <= {DATA_W{1'b0}};
         a_r[2]      <= {DATA_W{1'b0}};
         a_r[3]      <= {DATA_W{1'b0}};
         mx_start_r  <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         // Handshake flags are decoded from the next state so they line up with state_r.
         mx_start_r <= (state_nxt_s == START);
         in_ready_r <= (state_nxt_s == LOAD);
         busy_r     <= (state_nxt_s != LOAD);
         case (state_r)
            LOAD: begin
               if (beat_s) begin
                  a_r[idx_r] <= in_data;
                  idx_r      <= idx_r + 2'd1;
               end
            end
            START: cnt_r <= {CNT_W{1'b0}};
            WAIT: begin
               cnt_r <= cnt_r + CNT_W'(1);
               if (done_s) begin
                  out_data_r  <= mx_result;
                  out_valid_r <= 1'b1;
               end
            end
            OUT: begin
               if (take_s) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: out_valid_r <= 1'b0;
         endcase
      end
   end

`ifdef MAXNET_CHECK_EN
   logic [DATA_W-1:0] ref_max_r;
   logic              chk_err_r;

   function automatic logic f_is_zero(input logic [DATA_W-1:0] f);
      return (f[DATA_W-2:0] == {(DATA_W-1){1'b0}});
   endfunction

   function automatic logic f_equal(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return (a == b) || (f_is_zero(a) && f_is_zero(b));
   endfunction

   // IEEE ordering: sign first, then magnitude, with negatives reversed.
   function automatic logic f_greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic gt;
      if (f_is_zero(a) && f_is_zero(b)) begin
         gt = 1'b0;
      end else if (a[DATA_W-1] != b[DATA_W-1]) begin
         gt = ~a[DATA_W-1];
      end else if (a[DATA_W-1] == 1'b0) begin
         gt = (a[DATA_W-2:0] > b[DATA_W-2:0]);
      end else begin
         gt = (a[DATA_W-2:0] < b[DATA_W-2:0]);
      end
      return gt;
   endfunction

   // Reference max tracking and result check at capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_max_r <= {DATA_W{1'b0}};
         chk_err_r <= 1'b0;
      end else begin
         if ((state_r == LOAD) && beat_s) begin
            chk_err_r <= 1'b0;
            if ((idx_r == 2'd0) || f_greater(in_data, ref_max_r)) begin
               ref_max_r <= in_data;
            end
         end else if ((state_r == WAIT) && done_s) begin
            chk_err_r <= ~f_equal(mx_result, ref_max_r);
         end
      end
   end

   assign chk_err = chk_err_r;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder with a behavioural Maxnet stub (max of a0..a3, 10 cycles after start).
module tb_maxnet_feeder;
   localparam int W  = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] in_data = 32'h0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] mx_a0, mx_a1, mx_a2, mx_a3;
   logic          mx_start;
   logic [DW-1:0] mx_result;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          chk_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int starts[$];
   int dbl_pulse = 0;
   logic prev_start = 1'b0;

   logic          force_wrong = 1'b0;
   int            stub_cnt = 0;
   logic [DW-1:0] stub_result = 32'h0;

   maxnet_feeder #(.DATA_W(DW), .WAIT_CYCLES(W), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mx_a0(mx_a0), .mx_a1(mx_a1), .mx_a2(mx_a2), .mx_a3(mx_a3), .mx_start(mx_start),
      .mx_result(mx_result), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   // Monotone integer key for float ordering (+0 and -0 share a key).
   function automatic logic [31:0] fkey(input logic [31:0] f);
      logic [31:0] g;
      g = (f[30:0] == 31'h0) ? 32'h0 : f;
      return g[31] ? ~g : (g | 32'h8000_0000);
   endfunction

   function automatic logic [31:0] max4(input logic [31:0] a, b, c, d);
      logic [31:0] v [4];
      logic [31:0] m;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      m = v[0];
      for (int i = 1; i < 4; i++) if (fkey(v[i]) > fkey(m)) m = v[i];
      return m;
   endfunction

   // Maxnet stub.
   always @(posedge clk) begin
      if (rst) begin
         stub_cnt <= 0;
      end else if (mx_start) begin
         stub_cnt <= 10;
      end else if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1)
            stub_result <= force_wrong ? 32'h4080_0000 : max4(mx_a0, mx_a1, mx_a2, mx_a3);
      end
   end
   assign mx_result = stub_result;

   always @(posedge clk) cyc <= cyc + 1;

   // Record start pulses and flag any pulse wider than one cycle.
   always @(negedge clk) begin
      if (mx_start) starts.push_back(cyc);
      if (mx_start && prev_start) dbl_pulse <= dbl_pulse + 1;
      prev_start <= mx_start;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] w, input bit hold);
      int n;
      n = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("send_timeout", {31'h0, in_ready}, 32'h1);
      tick();
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int s0;
      logic [31:0] held;

      // Reset
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_start", {31'h0, mx_start}, 32'h0);
      chk("rst_ovalid", {31'h0, out_valid}, 32'h0);
      chk("rst_odata", out_data, 32'h0);
      chk("rst_a0", mx_a0, 32'h0);
      chk("rst_a3", mx_a3, 32'h0);
      chk("rst_chk", {31'h0, chk_err}, 32'h0);

      // 1: single group, in_valid held high
      out_ready = 1'b0;
      send(32'h41A0_0000, 1'b1);
      send(32'h40B0_0000, 1'b1);
      send(32'h42C8_8000, 1'b1);
      send(32'h4080_0000, 1'b0);
      chk("t1_start", {31'h0, mx_start}, 32'h1);
      chk("t1_a0", mx_a0, 32'h41A0_0000);
      chk("t1_a1", mx_a1, 32'h40B0_0000);
      chk("t1_a2", mx_a2, 32'h42C8_8000);
      chk("t1_a3", mx_a3, 32'h4080_0000);
      chk("t1_in_ready", {31'h0, in_ready}, 32'h0);
      tick();
      chk("t1_start_fall", {31'h0, mx_start}, 32'h0);
      chk("t1_busy", {31'h0, busy}, 32'h1);
      wait_out(n);
      chk("t1_ovalid", {31'h0, out_valid}, 32'h1);
      // start cycle, 16 WAIT cycles, then out_valid
      chk("t1_latency", n + 1, W + 1);
      chk("t1_odata", out_data, 32'h42C8_8000);

      // 2: back-pressure with a competing input word
      in_data  = 32'hDEAD_BEEF;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t2_ovalid_hold", {31'h0, out_valid}, 32'h1);
         chk("t2_odata_hold", out_data, 32'h42C8_8000);
         chk("t2_in_ready", {31'h0, in_ready}, 32'h0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t2_ovalid_drop", {31'h0, out_valid}, 32'h0);
      chk("t2_in_ready_back", {31'h0, in_ready}, 32'h1);
      tick();
      chk("t2_one_xfer", {31'h0, out_valid}, 32'h0);
      chk("t2_a0_kept", mx_a0, 32'h41A0_0000);
      chk("t2_a3_kept", mx_a3, 32'h4080_0000);

      // 3: gapped input
      begin
         logic [31:0] g [4];
         g[0] = 32'h8000_0000; g[1] = 32'h3F80_0000; g[2] = 32'h0000_0000; g[3] = 32'hBF80_0000;
         for (int k = 0; k < 4; k++) begin
            in_data  = g[k];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("t3_start", {31'h0, mx_start}, (k == 3) ? 32'h1 : 32'h0);
            if (k < 3) begin
               tick();
               chk("t3_gap_nostart", {31'h0, mx_start}, 32'h0);
               chk("t3_gap_ready", {31'h0, in_ready}, 32'h1);
            end
         end
         chk("t3_a0", mx_a0, 32'h8000_0000);
         chk("t3_a1", mx_a1, 32'h3F80_0000);
         chk("t3_a2", mx_a2, 32'h0000_0000);
         chk("t3_a3", mx_a3, 32'hBF80_0000);
         wait_out(n);
         chk("t3_ovalid", {31'h0, out_valid}, 32'h1);
         chk("t3_odata", out_data, 32'h3F80_0000);
         tick();
      end

      // 4: reset after two beats, then a fresh group of negatives
      send(32'h4700_0000, 1'b1);
      send(32'h4800_0000, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_rst_a0", mx_a0, 32'h0);
      chk("t4_rst_a1", mx_a1, 32'h0);
      chk("t4_rst_busy", {31'h0, busy}, 32'h0);
      send(32'hC000_0000, 1'b1);
      send(32'hBF80_0000, 1'b1);
      send(32'hC120_0000, 1'b1);
      send(32'hC040_0000, 1'b0);
      chk("t4_start", {31'h0, mx_start}, 32'h1);
      chk("t4_a0", mx_a0, 32'hC000_0000);
      wait_out(n);
      chk("t4_odata", out_data, 32'hBF80_0000);
      tick();

      // 5: stub returns a wrong maximum
      force_wrong = 1'b1;
      send(32'h41A0_0000, 1'b1);
      send(32'h40B0_0000, 1'b1);
      send(32'h42C8_8000, 1'b1);
      send(32'h4080_0000, 1'b0);
      wait_out(n);
      chk("t5_odata", out_data, 32'h4080_0000);
`ifdef MAXNET_CHECK_EN
      chk("t5_chk_err", {31'h0, chk_err}, 32'h1);
`else
      chk("t5_chk_err", {31'h0, chk_err}, 32'h0);
`endif
      force_wrong = 1'b0;
      tick();

      // 6: two groups back-to-back; first beat also clears chk_err
      send(32'h3F00_0000, 1'b1);
      chk("t5_chk_clear", {31'h0, chk_err}, 32'h0);
      send(32'h3E80_0000, 1'b1);
      send(32'h4000_0000, 1'b1);
      send(32'h3F40_0000, 1'b0);
      wait_out(n);
      chk("t6_res_a", out_data, 32'h4000_0000);
      chk("t6_chk_a", {31'h0, chk_err}, 32'h0);
      held = out_data;
      tick();
      send(32'hC200_0000, 1'b1);
      send(32'h4100_0000, 1'b1);
      send(32'h0000_0000, 1'b1);
      send(32'hC100_0000, 1'b0);
      wait_out(n);
      chk("t6_res_b", out_data, 32'h4100_0000);
      chk("t6_order", held, 32'h4000_0000);
      tick();

      chk("start_count", starts.size(), 6);
      chk("start_width", dbl_pulse, 0);
      if (starts.size() >= 2) begin
         s0 = starts[starts.size()-1] - starts[starts.size()-2];
         chk("t6_gap_min", {31'h0, (s0 >= 18)}, 32'h1);
         chk("t6_gap", s0, 22);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
